// File: rtl/bldc_pkg.sv
// Shared drive encodings, Hall decode and commutation table for the six-step BLDC driver.
package bldc_pkg;

  localparam logic [1:0] PH_OFF = 2'b00;
  localparam logic [1:0] PH_LO  = 2'b01;
  localparam logic [1:0] PH_HI  = 2'b10;

  typedef struct packed {
    logic       invalid;
    logic [2:0] sector;
  } hall_dec_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
  } phase_req_t;

  function automatic hall_dec_t hall_decode(input logic [2:0] h);
    hall_dec_t d;
    d.invalid = 1'b0;
    d.sector  = 3'd0;
    case (h)
      3'd5:    d.sector = 3'd0;
      3'd4:    d.sector = 3'd1;
      3'd6:    d.sector = 3'd2;
      3'd2:    d.sector = 3'd3;
      3'd3:    d.sector = 3'd4;
      3'd1:    d.sector = 3'd5;
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

  function automatic phase_req_t comm_row(input logic [2:0] sector);
    phase_req_t r;
    case (sector)
      3'd0:    r = {PH_HI, PH_LO, PH_OFF};
      3'd1:    r = {PH_HI, PH_OFF, PH_LO};
      3'd2:    r = {PH_OFF, PH_HI, PH_LO};
      3'd3:    r = {PH_LO, PH_HI, PH_OFF};
      3'd4:    r = {PH_LO, PH_OFF, PH_HI};
      3'd5:    r = {PH_OFF, PH_LO, PH_HI};
      default: r = {PH_OFF, PH_OFF, PH_OFF};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] sector_inc(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sector_dec(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  // Reverse rotation drives the row half a turn away.
  function automatic logic [2:0] sector_rev(input logic [2:0] s);
    return (s >= 3'd3) ? s - 3'd3 : s + 3'd3;
  endfunction

  function automatic logic [1:0] chop(input logic [1:0] r, input logic pwm_on);
    return (r == PH_HI && !pwm_on) ? PH_OFF : r;
  endfunction

endpackage

// File: rtl/bldc_deadtime.sv
// Per-phase gate register: turn-off is immediate, turn-on waits until the opposite
// gate has been off for DEADTIME clocks, so the two gates are never on together.
module bldc_deadtime
  import bldc_pkg::*;
#(
  parameter int unsigned DEADTIME = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gate_o
);

  localparam logic [7:0] DtCnt = 8'(DEADTIME);

  logic [1:0] gate_d, gate_q;
  logic [7:0] hi_off_d, hi_off_q;
  logic [7:0] lo_off_d, lo_off_q;

  always_comb begin
    hi_off_d = gate_q[1] ? 8'd0 : ((hi_off_q == DtCnt) ? DtCnt : hi_off_q + 8'd1);
    lo_off_d = gate_q[0] ? 8'd0 : ((lo_off_q == DtCnt) ? DtCnt : lo_off_q + 8'd1);
    gate_d[1] = (req_i == PH_HI) && (lo_off_d == DtCnt);
    gate_d[0] = (req_i == PH_LO) && (hi_off_d == DtCnt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gate_q   <= PH_OFF;
      hi_off_q <= DtCnt;
      lo_off_q <= DtCnt;
    end else begin
      gate_q   <= gate_d;
      hi_off_q <= hi_off_d;
      lo_off_q <= lo_off_d;
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/bldc_six_step_pwm.sv
// Six-step BLDC commutation with PWM chopping of the high side, direction, brake/coast,
// Hall fault detection and per-phase dead time.
module bldc_six_step_pwm
  import bldc_pkg::*;
#(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DEADTIME = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              dir,
  input  logic              brake,
  input  logic [DUTY_W-1:0] duty,
  input  logic [2:0]        H,
  output logic [1:0]        A,
  output logic [1:0]        B,
  output logic [1:0]        C,
  output logic [2:0]        sector,
  output logic              fault
);

  localparam int unsigned       PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0]   PreLast = PreW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CntMax  = {{(DUTY_W - 1){1'b1}}, 1'b0};
  // Synchroniser resets to the sector-0 code so a clean start raises no fault.
  localparam logic [2:0]        HallRst = 3'b101;

  logic [PreW-1:0]   pre_d, pre_q;
  logic [DUTY_W-1:0] cnt_d, cnt_q;
  logic [DUTY_W-1:0] duty_d, duty_q;
  logic [2:0]        h_s1_q, h_s2_q;
  logic [2:0]        sector_d, sector_q;
  logic              fault_d, fault_q;
  logic              tick, pwm_on, jump;
  hall_dec_t         hall;
  phase_req_t        row, req;

  always_comb begin
    tick   = (pre_q == PreLast);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (tick) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        duty_d = duty;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pwm_on = (cnt_q < duty_q);
  end

  always_comb begin
    hall = hall_decode(h_s2_q);
    jump = enable && !hall.invalid && (hall.sector != sector_q) &&
           (hall.sector != sector_inc(sector_q)) && (hall.sector != sector_dec(sector_q));
    fault_d = fault_q;
    if (hall.invalid || jump) begin
      fault_d = 1'b1;
    end else if (!enable) begin
      fault_d = 1'b0;
    end
    sector_d = sector_q;
    if (!hall.invalid && !jump && (!fault_q || !enable)) begin
      sector_d = hall.sector;
    end
  end

  // fault_d gates the request so a bad Hall code kills the drive on the same edge it latches.
  always_comb begin
    row = comm_row(dir ? sector_rev(sector_q) : sector_q);
    req = {PH_OFF, PH_OFF, PH_OFF};
    if (fault_d || !enable) begin
      req = {PH_OFF, PH_OFF, PH_OFF};
    end else if (brake) begin
      req = {PH_LO, PH_LO, PH_LO};
    end else begin
      req.a = chop(row.a, pwm_on);
      req.b = chop(row.b, pwm_on);
      req.c = chop(row.c, pwm_on);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      h_s1_q   <= HallRst;
      h_s2_q   <= HallRst;
      sector_q <= 3'd0;
      fault_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      h_s1_q   <= H;
      h_s2_q   <= h_s1_q;
      sector_q <= sector_d;
      fault_q  <= fault_d;
    end
  end

  bldc_deadtime #(.DEADTIME(DEADTIME)) u_dt_a (.clk_i(CLK), .rst_i(RST), .req_i(req.a), .gate_o(A));
  bldc_deadtime #(.DEADTIME(DEADTIME)) u_dt_b (.clk_i(CLK), .rst_i(RST), .req_i(req.b), .gate_o(B));
  bldc_deadtime #(.DEADTIME(DEADTIME)) u_dt_c (.clk_i(CLK), .rst_i(RST), .req_i(req.c), .gate_o(C));

  assign sector = sector_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_bldc_six_step_pwm.sv
// Scoreboard bench for bldc_six_step_pwm: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them.
module tb_bldc_six_step_pwm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable, dir, brake;
  logic [3:0] duty;
  logic [2:0] H;
  logic [1:0] A, B, C;
  logic [2:0] sector;
  logic       fault;

  bldc_six_step_pwm #(.DUTY_W(4), .PRESCALE(1), .DEADTIME(2)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .dir(dir), .brake(brake), .duty(duty),
    .H(H), .A(A), .B(B), .C(C), .sector(sector), .fault(fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         chk_g;
    logic [5:0] g;
    logic [2:0] sec;
    logic       flt;
  } exp_t;

  exp_t  q[$];
  string names[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [5:0] row_of(int s);
    case (s)
      0: return 6'b10_01_00;
      1: return 6'b10_00_01;
      2: return 6'b00_10_01;
      3: return 6'b01_10_00;
      4: return 6'b01_00_10;
      5: return 6'b00_01_10;
      default: return 6'b00_00_00;
    endcase
  endfunction

  task automatic exp_gates(input int at, input logic [5:0] g, input string nm);
    exp_t e;
    e.cyc = at; e.chk_g = 1'b1; e.g = g; e.sec = 3'd0; e.flt = 1'b0;
    q.push_back(e);
    names.push_back(nm);
  endtask

  task automatic exp_sf(input int at, input logic [2:0] s, input logic f, input string nm);
    exp_t e;
    e.cyc = at; e.chk_g = 1'b0; e.g = 6'd0; e.sec = s; e.flt = f;
    q.push_back(e);
    names.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    exp_t  e;
    string nm;
    n_tests++;
    if (A == 2'b11 || B == 2'b11 || C == 2'b11) begin
      n_fail++;
      $display("FAIL shoot_through @%0d: A/B/C=%b/%b/%b, no phase may be 11", cyc, A, B, C);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e  = q.pop_front();
      nm = names.pop_front();
      n_tests++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d was skipped (now %0d)", nm, e.cyc, cyc);
      end else if (e.chk_g) begin
        if ({A, B, C} !== e.g) begin
          n_fail++;
          $display("FAIL %s @%0d: A/B/C=%b/%b/%b, expected %b/%b/%b", nm, cyc, A, B, C,
                   e.g[5:4], e.g[3:2], e.g[1:0]);
        end
      end else if (sector !== e.sec || fault !== e.flt) begin
        n_fail++;
        $display("FAIL %s @%0d: sector=%0d fault=%b, expected sector=%0d fault=%b", nm, cyc,
                 sector, fault, e.sec, e.flt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  int hseq[6] = '{4, 6, 2, 3, 1, 5};
  int sseq[6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    int k, w, base, pos, dv;
    logic on;
    RST = 1'b1; enable = 1'b0; dir = 1'b0; brake = 1'b0; duty = 4'd8; H = 3'd5;
    step(1);
    for (int i = 0; i < 4; i++) begin
      exp_gates(cyc + i, 6'b0, "reset_gates");
      exp_sf(cyc + i, 3'd0, 1'b0, "reset_state");
    end
    step(4);
    RST = 1'b0;
    enable = 1'b1;
    k = cyc;

    // Forward chop: duty 8 latched at the first wrap (edge k+15).
    for (int j = 1; j <= 45; j++) begin
      on = (j >= 16) && (((j - 16) % 15) < 8);
      exp_gates(k + j, {(on ? 2'b10 : 2'b00), 2'b01, 2'b00}, "fwd_chop");
      if (j == 3) exp_sf(k + 3, 3'd0, 1'b0, "sector_after_reset");
    end
    step(45);
    duty = 4'd15;
    step(16);

    // Dead time on direction change in sector 0.
    base = cyc; dir = 1'b1;
    exp_gates(base + 1, 6'b00_00_00, "deadtime_off");
    exp_gates(base + 2, 6'b00_00_00, "deadtime_wait");
    exp_gates(base + 3, 6'b01_10_00, "deadtime_on");
    step(8);

    for (int i = 0; i < 6; i++) begin
      H = 3'(hseq[i]); base = cyc;
      exp_sf(base + 3, 3'(sseq[i]), 1'b0, "rev_sector");
      exp_gates(base + 4, row_of((sseq[i] + 3) % 6), "rev_drive");
      step(8);
    end

    base = cyc; dir = 1'b0;
    exp_gates(base + 3, row_of(0), "dir_back_fwd");
    step(8);
    for (int i = 0; i < 6; i++) begin
      H = 3'(hseq[i]); base = cyc;
      exp_sf(base + 3, 3'(sseq[i]), 1'b0, "fwd_sector");
      exp_gates(base + 4, row_of(sseq[i]), "fwd_drive");
      step(8);
    end

    base = cyc; brake = 1'b1;
    exp_gates(base + 1, 6'b00_01_01, "brake_break");
    exp_gates(base + 3, 6'b01_01_01, "brake_make");
    step(5);
    base = cyc; brake = 1'b0;
    exp_gates(base + 1, 6'b00_01_00, "unbrake_break");
    exp_gates(base + 3, 6'b10_01_00, "unbrake_make");
    step(6);

    // Invalid Hall code, then sticky behaviour and clear via enable low.
    base = cyc; H = 3'd7;
    exp_sf(base + 3, 3'd0, 1'b1, "fault_hall7");
    exp_gates(base + 3, 6'b0, "fault_hall7_gates");
    step(6);
    base = cyc; H = 3'd5;
    exp_sf(base + 4, 3'd0, 1'b1, "fault_sticky");
    exp_gates(base + 4, 6'b0, "fault_sticky_gates");
    step(6);
    enable = 1'b0; step(1); enable = 1'b1;
    exp_sf(cyc, 3'd0, 1'b0, "fault_clear");
    exp_gates(cyc + 2, row_of(0), "fault_clear_drive");
    step(6);

    base = cyc; H = 3'd6;
    exp_sf(base + 3, 3'd0, 1'b1, "fault_jump");
    exp_gates(base + 3, 6'b0, "fault_jump_gates");
    step(5);
    H = 3'd5; step(4);
    enable = 1'b0; step(2); enable = 1'b1;
    exp_sf(cyc, 3'd0, 1'b0, "fault_jump_clear");
    step(6);

    // Duty 0, then 4, then 12 written mid-period.
    while (((cyc - k) % 15) != 0) step(1);
    duty = 4'd0;
    step(15);
    w = cyc; duty = 4'd4;
    for (int j = 1; j <= 45; j++) begin
      pos = (j - 1) % 15;
      dv  = ((j - 1) / 15 == 0) ? 0 : (((j - 1) / 15 == 1) ? 4 : 12);
      exp_gates(w + j, {((pos < dv) ? 2'b10 : 2'b00), 2'b01, 2'b00}, "duty_edges");
    end
    step(22);
    duty = 4'd12;
    step(25);

    for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
